ifu_prefetch: RTL

IFU_PREFETCH -- requirements
Module: ifu_prefetch

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_fifo.sv | 60 ++++++
 rtl/ifu_prefetch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and defaults for the instruction prefetch unit
package ifu_pkg;

    localparam int unsigned IFU_ADDR_W = 32;
    localparam int unsigned IFU_DATA_W = 32;
    localparam logic [IFU_ADDR_W-1:0] IFU_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD
    } ifu_state_e;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_DATA_W-1:0] inst;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - DEPTH-entry synchronous FIFO with flush, count and full/empty
module ifu_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: reads of an empty FIFO are masked by the consumer.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - credit-limited instruction prefetcher with redirect flush
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IFU_ADDR_W,
    parameter int unsigned       DATA_W   = IFU_DATA_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
);

    localparam int unsigned       CNT_W     = $clog2(DEPTH) + 1;
    localparam int unsigned       ENT_W     = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(DEPTH - 1);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
    logic              redir_pend_q, redir_pend_d;
    logic              req_fire;
    logic              pop;
    logic              push;
    logic [ENT_W-1:0]  head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign mem_req_valid = (state_q == S_REQ) && !rst;
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign inst_valid    = !fifo_empty;
    assign pop           = inst_valid && inst_ready;
    assign inst          = fifo_empty ? '0 : head[DATA_W-1:0];
    assign inst_pc       = fifo_empty ? '0 : head[ENT_W-1:DATA_W];

    ifu_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W),
        .CW    (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i ({rsp_pc_q, mem_rsp_data}),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            rsp_pc_q     <= '0;
            redir_pc_q   <= '0;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            rsp_pc_q     <= rsp_pc_d;
            redir_pc_q   <= redir_pc_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        rsp_pc_d     = rsp_pc_q;
        redir_pc_d   = redir_pc_q;
        redir_pend_d = redir_pend_q;
        push         = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    rsp_pc_d     = fetch_pc_q;
                    redir_pend_d = 1'b0;
                    if (redirect_valid) begin
                        fetch_pc_d = redirect_pc;
                        state_d    = S_DROP;
                    end else if (redir_pend_q) begin
                        fetch_pc_d = redir_pc_q;
                        state_d    = S_DROP;
                    end else begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                        state_d    = S_WAIT;
                    end
                end else if (redirect_valid) begin
                    // The presented request must stay stable; remember where to go next.
                    redir_pend_d = 1'b1;
                    redir_pc_d   = redirect_pc;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = mem_rsp_valid ? S_REQ : S_DROP;
                end else if (mem_rsp_valid) begin
                    push    = 1'b1;
                    state_d = (fifo_count == LAST_SLOT && !pop) ? S_HOLD : S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) fetch_pc_d = redirect_pc;
                if (mem_rsp_valid)  state_d = S_REQ;
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = S_REQ;
                end else if (pop || !fifo_full) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop)        fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (fifo_empty) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
